// File: rtl/reg_dump_unit.sv
// rtl/reg_dump_unit.sv - block register read-out streamer for the register file read port
//
// Purpose:
//   On a start pulse, takes ownership of the register file read port through
//   bus_req/bus_gnt, reads a contiguous (wrapping) block of registers, and
//   streams each value with its address over a valid/ready interface.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       1-cycle dump request, ignored while busy
//   first_addr  first register address, sampled with start
//   count       number of registers to dump, sampled with start
//   busy        high from accepted start until done
//   bus_req     read port ownership request
//   bus_gnt     read port granted, may drop at any time
//   rd_en       register file read enable
//   rd_sel      register file read address (0 outside ISSUE)
//   rd_data     register file read data
//   dump_valid  dump_data/dump_addr/dump_last valid
//   dump_ready  consumer accepts the beat on valid & ready
//   dump_data   captured register value
//   dump_addr   address the value was read from
//   dump_last   final beat of the dump
//   done        1-cycle completion pulse

module reg_dump_unit #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   REM_ONE    = (ADDR_W+1)'(1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [ADDR_W:0]     rem_q;
  logic [ADDR_W:0]     rem_nxt;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   daddr_q;
  logic                done_q;
  logic                done_nxt;
  logic                capture;
  logic [ADDR_W-1:0]   first_clamped;

  // Out-of-range start addresses fold to register 0.
  assign first_clamped = ({1'b0, first_addr} >= NUM_REGS_W) ? '0 : first_addr;

  assign dump_data = data_q;
  assign dump_addr = daddr_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      daddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      rem_q  <= rem_nxt;
      done_q <= done_nxt;
      if (capture) begin
        data_q  <= rd_data;
        daddr_q <= addr_q;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    rem_nxt    = rem_q;
    done_nxt   = 1'b0;
    capture    = 1'b0;
    busy       = 1'b0;
    bus_req    = 1'b0;
    rd_en      = 1'b0;
    rd_sel     = '0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_nxt  = first_clamped;
            rem_nxt   = count;
            state_nxt = S_REQ;
          end else begin
            // Empty dump: acknowledge without touching the bus.
            done_nxt = 1'b1;
          end
        end
      end

      S_REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        rd_en   = bus_gnt;
        rd_sel  = addr_q;
        if (bus_gnt) begin
          if (RD_LATENCY == 0) begin
            capture   = 1'b1;
            state_nxt = S_OUT;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Read was already issued; the data arrives regardless of the grant.
        busy      = 1'b1;
        bus_req   = 1'b1;
        capture   = 1'b1;
        state_nxt = S_OUT;
      end

      S_OUT: begin
        busy       = 1'b1;
        bus_req    = 1'b1;
        dump_valid = 1'b1;
        dump_last  = (rem_q == REM_ONE);
        if (dump_ready) begin
          if (rem_q == REM_ONE) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            rem_nxt   = rem_q - REM_ONE;
            addr_nxt  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb/tb_reg_dump_unit.sv - self-checking bench for reg_dump_unit

module tb_reg_dump_unit;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              bus_req;
  logic              bus_gnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_last;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];

  int checks = 0;
  int errors = 0;

  reg_dump_unit #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .count(count),
    .busy(busy), .bus_req(bus_req), .bus_gnt(bus_gnt), .rd_en(rd_en),
    .rd_sel(rd_sel), .rd_data(rd_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
    .dump_last(dump_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with one cycle of read latency; garbage when not read so a
  // mistimed capture shows up as wrong data.
  always @(posedge clk) begin
    if (rd_en) rd_data <= regs[rd_sel];
    else       rd_data <= DATA_W'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},       32'(busy),       32'(0));
    check({tag, " bus_req"},    32'(bus_req),    32'(0));
    check({tag, " rd_en"},      32'(rd_en),      32'(0));
    check({tag, " rd_sel"},     32'(rd_sel),     32'(0));
    check({tag, " dump_valid"}, 32'(dump_valid), 32'(0));
    check({tag, " dump_data"},  32'(dump_data),  32'(0));
    check({tag, " dump_addr"},  32'(dump_addr),  32'(0));
    check({tag, " dump_last"},  32'(dump_last),  32'(0));
    check({tag, " done"},       32'(done),       32'(0));
  endtask

  // Runs one dump and checks each beat against the expected address/data list.
  // hold_beat/hold_cycles: withhold dump_ready on that beat; gnt_stall: cycles
  // of bus_gnt=0 after the request; rand_ready: random dump_ready;
  // reset_beat: assert reset while that beat is presented.
  task automatic do_dump(input int fa, input int cnt, input int hold_beat,
                         input int hold_cycles, input int gnt_stall,
                         input bit rand_ready, input int reset_beat);
    int exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    int fa_c, beat, held, stall_seen, hs_cyc;
    bit finished;

    fa_c = (fa >= NUM_REGS) ? 0 : fa;
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back((fa_c + i) % NUM_REGS);
      exp_data.push_back(regs[(fa_c + i) % NUM_REGS]);
    end

    @(negedge clk);
    start      = 1'b1;
    first_addr = ADDR_W'(fa);
    count      = (ADDR_W+1)'(cnt);
    bus_gnt    = (gnt_stall == 0);
    dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;

    if (cnt == 0) begin
      check("empty done",    32'(done),       32'(1));
      check("empty busy",    32'(busy),       32'(0));
      check("empty bus_req", 32'(bus_req),    32'(0));
      check("empty valid",   32'(dump_valid), 32'(0));
      @(negedge clk);
      check("empty done drop", 32'(done),    32'(0));
      check("empty busy2",     32'(busy),    32'(0));
      check("empty bus_req2",  32'(bus_req), 32'(0));
      return;
    end

    check("busy after start",    32'(busy),    32'(1));
    check("bus_req after start", 32'(bus_req), 32'(1));

    beat = 0; held = 0; stall_seen = 0; hs_cyc = -1; finished = 1'b0;
    for (int cyc = 0; cyc < 500 && !finished; cyc++) begin
      if (gnt_stall > 0 && bus_gnt == 1'b0) begin
        check("rd_en in gnt stall", 32'(rd_en), 32'(0));
        stall_seen++;
        if (stall_seen >= gnt_stall) bus_gnt = 1'b1;
      end
      if (rd_en && beat < cnt)
        check("rd_sel", 32'(rd_sel), 32'(exp_addr[beat]));
      if (!dump_valid) begin
        check("done early", 32'(done), 32'(0));
        dump_ready = rand_ready ? 1'($urandom) : 1'b1;
      end else begin
        check("dump_addr", 32'(dump_addr), 32'(exp_addr[beat]));
        check("dump_data", 32'(dump_data), 32'(exp_data[beat]));
        check("dump_last", 32'(dump_last), 32'(beat == cnt - 1));
        if (beat == reset_beat) begin
          rst = 1'b0;
          #1;
          check_all_zero("mid-dump reset");
          @(negedge clk);
          rst = 1'b1;
          dump_ready = 1'b1;
          finished = 1'b1;
        end else if (beat == hold_beat && held < hold_cycles) begin
          check("rd_en while held", 32'(rd_en), 32'(0));
          dump_ready = 1'b0;
          held++;
        end else begin
          dump_ready = rand_ready ? 1'($urandom) : 1'b1;
        end
        if (!finished && dump_ready) begin
          if (gnt_stall == 0 && hold_cycles == 0 && !rand_ready && hs_cyc >= 0)
            check("beat spacing", 32'(cyc - hs_cyc), 32'(3));
          hs_cyc = cyc;
          beat++;
          if (beat == cnt) begin
            @(negedge clk);
            check("done pulse",     32'(done),       32'(1));
            check("busy at done",   32'(busy),       32'(0));
            check("bus_req done",   32'(bus_req),    32'(0));
            check("valid at done",  32'(dump_valid), 32'(0));
            @(negedge clk);
            check("done one cycle", 32'(done), 32'(0));
            finished = 1'b1;
          end
        end
      end
      if (!finished) @(negedge clk);
    end
    if (!finished) check("dump timeout", 32'(0), 32'(1));
    dump_ready = 1'b1;
    bus_gnt    = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    first_addr = '0;
    count      = '0;
    bus_gnt    = 1'b1;
    dump_ready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(8'h10 + i);

    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Basic dump, wrap-around, empty dump.
    do_dump(2, 3, -1, 0, 0, 1'b0, -1);
    do_dump(6, 4, -1, 0, 0, 1'b0, -1);
    do_dump(0, 0, -1, 0, 0, 1'b0, -1);
    // Back-pressure on first beat, grant stall.
    do_dump(1, 3, 0, 5, 0, 1'b0, -1);
    do_dump(3, 3, -1, 0, 4, 1'b0, -1);
    // Reset during beat 2, then a normal 2-register dump.
    do_dump(0, 4, -1, 0, 0, 1'b0, 1);
    check_all_zero("after reset release");
    do_dump(5, 2, -1, 0, 0, 1'b0, -1);

    // Random register contents, start points, lengths and back-pressure.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'($urandom);
      do_dump(int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(1, 15)),
              -1, 0, 0, 1'b1, -1);
    end
    do_dump(7, 15, -1, 0, 0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
